// File: rtl/timer_sb_ctrl.sv
// System-bus timer peripheral: free-running 64-bit cycle counter, programmable
// periodic event generator (off / N-times / forever) and a level interrupt
// request that the core acknowledges with irq_ret_i.
module timer_sb_ctrl #(
    parameter int unsigned CNT_W   = 64,
    parameter logic [31:0] RST_KEY = 32'h1
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        irq_req_o,
    input  logic        irq_ret_i
);

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeNtimes  = 2'd1,
        ModeForever = 2'd2,
        ModeRsvd    = 2'd3
    } mode_e;

    logic [CNT_W-1:0] sys_cnt_q;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] evt_cnt_q;
    mode_e            mode_q;
    logic [31:0]      repeat_q;
    logic [31:0]      read_data_q;
    logic             irq_q;

    logic [3:0]  sel;
    logic        wr_en;
    logic        rd_en;
    logic        wr_delay_lo;
    logic        wr_delay_hi;
    logic        wr_mode;
    logic        wr_repeat;
    logic        wr_reset;
    logic [31:0] rd_mux;
    logic        active;
    logic        fire;
    logic        auto_step;

    assign read_data_o = read_data_q;
    assign irq_req_o   = irq_q;

    // Bus decode: word-aligned accesses only, register chosen by addr[5:2].
    always_comb begin
        sel         = addr_i[5:2];
        wr_en       = req_i & write_enable_i & (addr_i[1:0] == 2'b00);
        rd_en       = req_i & ~write_enable_i & (addr_i[1:0] == 2'b00);
        wr_delay_lo = wr_en && (sel == 4'h2);
        wr_delay_hi = wr_en && (sel == 4'h3);
        wr_mode     = wr_en && (sel == 4'h4);
        wr_repeat   = wr_en && (sel == 4'h5);
        wr_reset    = wr_en && (sel == 4'h9) && (write_data_i == RST_KEY);
        unique case (sel)
            4'h0:    rd_mux = sys_cnt_q[31:0];
            4'h1:    rd_mux = sys_cnt_q[CNT_W-1:32];
            4'h2:    rd_mux = delay_q[31:0];
            4'h3:    rd_mux = delay_q[CNT_W-1:32];
            4'h4:    rd_mux = {30'd0, mode_q};
            4'h5:    rd_mux = repeat_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // Event qualification: the generator only runs with a non-zero period and a
    // mode that still has events left to produce.
    always_comb begin
        active    = (delay_q != '0) &&
                    ((mode_q == ModeForever) || ((mode_q == ModeNtimes) && (repeat_q != 32'd0)));
        fire      = active && (evt_cnt_q == (delay_q - CNT_W'(1)));
        // A bus write to mode or repeat_counter overrides the automatic countdown.
        auto_step = fire && (mode_q == ModeNtimes) && !wr_mode && !wr_repeat;
    end

    // Free-running cycle counter; only the hardware reset clears it.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sys_cnt_q <= '0;
        end else begin
            sys_cnt_q <= sys_cnt_q + CNT_W'(1);
        end
    end

    // Control registers, event FSM, interrupt and registered read data.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            delay_q     <= '0;
            evt_cnt_q   <= '0;
            mode_q      <= ModeOff;
            repeat_q    <= 32'd0;
            irq_q       <= 1'b0;
            read_data_q <= 32'd0;
        end else if (wr_reset) begin
            delay_q     <= '0;
            evt_cnt_q   <= '0;
            mode_q      <= ModeOff;
            repeat_q    <= 32'd0;
            irq_q       <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            // Any configuration write restarts the period from that edge.
            if (wr_delay_lo || wr_delay_hi || wr_mode || wr_repeat) begin
                evt_cnt_q <= '0;
            end else if (fire) begin
                evt_cnt_q <= '0;
            end else if (active) begin
                evt_cnt_q <= evt_cnt_q + CNT_W'(1);
            end else begin
                evt_cnt_q <= '0;
            end

            // Set wins over acknowledge; repeated events merge into one level.
            if (fire) begin
                irq_q <= 1'b1;
            end else if (irq_ret_i) begin
                irq_q <= 1'b0;
            end

            if (wr_delay_lo) begin
                delay_q[31:0] <= write_data_i;
            end
            if (wr_delay_hi) begin
                delay_q[CNT_W-1:32] <= write_data_i;
            end

            if (wr_repeat) begin
                repeat_q <= write_data_i;
            end else if (auto_step) begin
                repeat_q <= repeat_q - 32'd1;
            end

            if (wr_mode) begin
                mode_q <= mode_e'(write_data_i[1:0]);
            end else if (auto_step && (repeat_q == 32'd1)) begin
                mode_q <= ModeOff;
            end

            if (rd_en) begin
                read_data_q <= rd_mux;
            end
        end
    end

endmodule
